repair_rx: RTL and testbench

- Responder side of the MBTRAIN.REPAIR sideband handshake. It answers the partner's INIT, APPLY_DEGRADE and END requests with the matching responses.
- It decodes the partner's data-lane encoding into a 16-bit functional-lane mask that MBTRAIN uses after REPAIR.
- It sits beside the REPAIR initiator under the MBTRAIN sequencer and shares the sideband message and valid/busy interface with it.

---
 rtl/repair_pkg.sv | 30 +++
 rtl/repair_lane_decode.sv | 34 +++
 rtl/repair_rx.sv | 143 ++++++++++++++
 tb/tb_repair_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/repair_pkg.sv
// Shared definitions for the MBTRAIN.REPAIR sideband handshake: message codes,
// data-lane encodings and FSM state encodings, reused by initiator and responder.
package repair_pkg;

    // Sideband message codes exchanged during REPAIR.
    typedef enum logic [3:0] {
        MSG_NONE  = 4'b0000,
        INIT_REQ  = 4'b0001,
        INIT_RSP  = 4'b0010,
        END_REQ   = 4'b0101,
        END_RSP   = 4'b0110,
        APPLY_REQ = 4'b0111,
        APPLY_RSP = 4'b1000
    } repair_msg_e;

    // Data-lane encodings carried with APPLY_DEGRADE_REQUEST.
    localparam logic [2:0] ENC_LOWER_HALF = 3'b001;  // lanes 0..7
    localparam logic [2:0] ENC_UPPER_HALF = 3'b010;  // lanes 8..15
    localparam logic [2:0] ENC_ALL_LANES  = 3'b011;  // lanes 0..15

    // Handshake states shared by the REPAIR initiator and responder.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_INIT   = 3'd1,
        ST_WAIT_APPLY  = 3'd2,
        ST_WAIT_END    = 3'd3,
        ST_TEST_FINISH = 3'd4
    } repair_state_e;

endpackage

// File: rtl/repair_lane_decode.sv
// Combinational decode of the partner's 3-bit data-lane encoding into a
// 16-bit functional-lane mask plus a degrade-error flag for illegal codes.
module repair_lane_decode
    import repair_pkg::*;
(
    input  logic [2:0]  enc,
    output logic [15:0] mask,
    output logic        error
);

    // Map each legal encoding to its lane set; anything else is a degrade error.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        mask  = 16'h0000;
        error = 1'b1;
        case (enc)
            ENC_ALL_LANES: begin
                mask  = 16'hFFFF;
                error = 1'b0;
            end
            ENC_LOWER_HALF: begin
                mask  = 16'h00FF;
                error = 1'b0;
            end
            ENC_UPPER_HALF: begin
                mask  = 16'hFF00;
                error = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/repair_rx.sv
// Responder side of the MBTRAIN.REPAIR sideband handshake. Answers INIT,
// APPLY_DEGRADE and END requests and latches the resulting lane mask.
// Optional feature: define REPAIR_RX_TIMEOUT_EN to add a per-state timeout
// with a sticky o_timeout flag; without it o_timeout is tied to 0.
module repair_rx
    import repair_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter int          CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [3:0]  i_sideband_message,
    input  logic        i_sideband_valid,
    input  logic [2:0]  i_sideband_data_lanes_encoding,
    input  logic        i_busy_negedge_detected,
    input  logic        i_valid_tx,
    output logic [3:0]  o_sideband_message,
    output logic        o_valid_rx,
    output logic [15:0] o_lane_mask,
    output logic        o_degrade_error,
    output logic        o_test_ack,
    output logic        o_timeout
);

    // The timeout compare value must be representable in the counter.
    if (int'(TIMEOUT_CYCLES) >= (1 << CNT_W)) begin : g_bad_cfg
        $error("repair_rx: TIMEOUT_CYCLES does not fit in CNT_W bits");
    end

    repair_state_e state, state_next;
    logic          acc_init, acc_apply, acc_end, acc_any;
    logic          timeout_hit;
    logic          restart_blocked;
    logic [15:0]   dec_mask;
    logic          dec_error;

    repair_lane_decode u_lane_decode (
        .enc   (i_sideband_data_lanes_encoding),
        .mask  (dec_mask),
        .error (dec_error)
    );

    // A request is accepted only when it is the one the current state expects.
    assign acc_init  = i_en && i_sideband_valid && (state == ST_WAIT_INIT)
                       && (i_sideband_message == INIT_REQ);
    assign acc_apply = i_en && i_sideband_valid && (state == ST_WAIT_APPLY)
                       && (i_sideband_message == APPLY_REQ);
    assign acc_end   = i_en && i_sideband_valid && (state == ST_WAIT_END)
                       && (i_sideband_message == END_REQ);
    assign acc_any   = acc_init || acc_apply || acc_end;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; dropping i_en overrides everything, accept beats timeout.
    always_comb begin
        state_next = state;
        if (!i_en) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:        if (!restart_blocked) state_next = ST_WAIT_INIT;
                ST_WAIT_INIT:   if (acc_init)         state_next = ST_WAIT_APPLY;
                                else if (timeout_hit) state_next = ST_IDLE;
                ST_WAIT_APPLY:  if (acc_apply)        state_next = ST_WAIT_END;
                                else if (timeout_hit) state_next = ST_IDLE;
                ST_WAIT_END:    if (acc_end)          state_next = ST_TEST_FINISH;
                                else if (timeout_hit) state_next = ST_IDLE;
                ST_TEST_FINISH: state_next = ST_TEST_FINISH;
                default:        state_next = ST_IDLE;
            endcase
        end
    end

    // Response, valid, ack and lane-mask registers. The mask and error survive
    // i_en dropping because MBTRAIN consumes them after REPAIR finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_sideband_message <= MSG_NONE;
            o_valid_rx         <= 1'b0;
            o_test_ack         <= 1'b0;
            o_lane_mask        <= 16'h0000;
            o_degrade_error    <= 1'b0;
        end else if (!i_en) begin
            o_sideband_message <= MSG_NONE;
            o_valid_rx         <= 1'b0;
            o_test_ack         <= 1'b0;
        end else if (acc_init) begin
            o_sideband_message <= INIT_RSP;
            o_valid_rx         <= 1'b1;
        end else if (acc_apply) begin
            o_sideband_message <= APPLY_RSP;
            o_valid_rx         <= 1'b1;
            o_lane_mask        <= dec_mask;
            o_degrade_error    <= dec_error;
        end else if (acc_end) begin
            o_sideband_message <= END_RSP;
            o_valid_rx         <= 1'b1;
            o_test_ack         <= 1'b1;
        end else if (i_busy_negedge_detected && !i_valid_tx) begin
            o_valid_rx         <= 1'b0;
        end
    end

`ifdef REPAIR_RX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 16'd1);

    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait         = (state == ST_WAIT_INIT) || (state == ST_WAIT_APPLY)
                             || (state == ST_WAIT_END);
    assign timeout_hit     = in_wait && (wait_cnt == TIMEOUT_LAST) && !acc_any;
    // After a timeout the FSM parks in IDLE until MBTRAIN drops i_en.
    assign restart_blocked = o_timeout;

    // Per-state wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (state_next != state) wait_cnt <= '0;
            else if (in_wait)        wait_cnt <= wait_cnt + CNT_W'(1);

            if (!i_en)            o_timeout <= 1'b0;
            else if (timeout_hit) o_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit     = 1'b0;
    assign restart_blocked = 1'b0;
    assign o_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_repair_rx.sv
// Self-checking bench for repair_rx: directed handshake scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_repair_rx;

    localparam logic [15:0] TB_TIMEOUT = 16'd20;
    localparam logic [3:0]  REQ [3] = '{4'b0001, 4'b0111, 4'b0101};
    localparam logic [3:0]  RSP [3] = '{4'b0010, 4'b1000, 4'b0110};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_en = 1'b0;
    logic [3:0]  i_sideband_message = 4'h0;
    logic        i_sideband_valid = 1'b0;
    logic [2:0]  i_sideband_data_lanes_encoding = 3'b000;
    logic        i_busy_negedge_detected = 1'b0;
    logic        i_valid_tx = 1'b0;
    logic [3:0]  o_sideband_message;
    logic        o_valid_rx;
    logic [15:0] o_lane_mask;
    logic        o_degrade_error;
    logic        o_test_ack;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: handshake progress as "number of requests completed".
    bit          m_active;
    int          m_step;
    int          m_wait;
    logic [3:0]  m_msg;
    logic        m_valid;
    logic [15:0] m_mask;
    logic        m_err;
    logic        m_ack;
    logic        m_timeout;

    repair_rx #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(16)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .i_en                           (i_en),
        .i_sideband_message             (i_sideband_message),
        .i_sideband_valid               (i_sideband_valid),
        .i_sideband_data_lanes_encoding (i_sideband_data_lanes_encoding),
        .i_busy_negedge_detected        (i_busy_negedge_detected),
        .i_valid_tx                     (i_valid_tx),
        .o_sideband_message             (o_sideband_message),
        .o_valid_rx                     (o_valid_rx),
        .o_lane_mask                    (o_lane_mask),
        .o_degrade_error                (o_degrade_error),
        .o_test_ack                     (o_test_ack),
        .o_timeout                      (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Lane mask from the encoding: bit0 selects the low byte, bit1 the high byte,
    // bit2 set or no bits set is illegal.
    function automatic logic [16:0] ref_decode(input logic [2:0] enc);
        logic [15:0] m;
        m = 16'h0000;
        if (!enc[2]) begin
            if (enc[0]) m[7:0]  = 8'hFF;
            if (enc[1]) m[15:8] = 8'hFF;
        end
        return {(m == 16'h0000), m};
    endfunction

    task automatic model_reset();
        m_active = 0; m_step = 0; m_wait = 0;
        m_msg = 4'h0; m_valid = 0; m_mask = 16'h0; m_err = 0; m_ack = 0; m_timeout = 0;
    endtask

    // Advance the model by one clock edge given the inputs applied for that edge.
    task automatic model_update(input logic en, input logic v, input logic [3:0] msg,
                                input logic [2:0] enc, input logic busy, input logic vtx);
        logic [16:0] d;
        if (!en) begin
            m_active = 0; m_msg = 4'h0; m_valid = 0; m_ack = 0; m_timeout = 0; m_wait = 0;
        end else if (!m_active) begin
            if (!m_timeout) begin
                m_active = 1; m_step = 0; m_wait = 0;
            end
            if (busy && !vtx) m_valid = 0;
        end else if (m_step < 3 && v && msg == REQ[m_step]) begin
            m_msg = RSP[m_step];
            m_valid = 1;
            if (m_step == 1) begin
                d = ref_decode(enc);
                m_mask = d[15:0];
                m_err  = d[16];
            end
            if (m_step == 2) m_ack = 1;
            m_step++;
            m_wait = 0;
        end else begin
            if (busy && !vtx) m_valid = 0;
`ifdef REPAIR_RX_TIMEOUT_EN
            if (m_step < 3) begin
                m_wait++;
                if (m_wait == int'(TB_TIMEOUT)) begin
                    m_timeout = 1;
                    m_active = 0;
                end
            end
`endif
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " msg"},   16'(o_sideband_message), 16'(m_msg));
        chk({tag, " valid"}, 16'(o_valid_rx),         16'(m_valid));
        chk({tag, " mask"},  o_lane_mask,             m_mask);
        chk({tag, " err"},   16'(o_degrade_error),    16'(m_err));
        chk({tag, " ack"},   16'(o_test_ack),         16'(m_ack));
        chk({tag, " tmo"},   16'(o_timeout),          16'(m_timeout));
    endtask

    // Apply inputs, clock once, then compare every output 1 time unit after the edge.
    task automatic cycle(input string tag, input logic en, input logic v,
                         input logic [3:0] msg, input logic [2:0] enc,
                         input logic busy, input logic vtx);
        i_en = en;
        i_sideband_valid = v;
        i_sideband_message = msg;
        i_sideband_data_lanes_encoding = enc;
        i_busy_negedge_detected = busy;
        i_valid_tx = vtx;
        model_update(en, v, msg, enc, busy, vtx);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic req(input string tag, input logic [3:0] msg, input logic [2:0] enc);
        cycle(tag, 1'b1, 1'b1, msg, enc, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic restart(input string tag);
        cycle(tag, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0);
        idle(tag);
    endtask

    initial begin
        logic [2:0] encs [4];
        encs = '{3'b001, 3'b010, 3'b000, 3'b101};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Normal flow with encoding 011.
        idle("enable");
        req("init", 4'b0001, 3'b000);
        chk("init rsp code", 16'(o_sideband_message), 16'h0002);
        cycle("busy clear", 1'b1, 1'b0, 4'h0, 3'b000, 1'b1, 1'b0);
        chk("valid cleared", 16'(o_valid_rx), 16'h0000);
        req("apply 011", 4'b0111, 3'b011);
        chk("mask full", o_lane_mask, 16'hFFFF);
        req("end", 4'b0101, 3'b000);
        chk("test ack", 16'(o_test_ack), 16'h0001);
        req("repeat end", 4'b0101, 3'b000);
        idle("finish hold");

        // Each remaining encoding in its own run.
        foreach (encs[k]) begin
            restart("enc restart");
            req("enc init", 4'b0001, 3'b000);
            req("enc apply", 4'b0111, encs[k]);
            chk("apply rsp code", 16'(o_sideband_message), 16'h0008);
        end

        // Out-of-order and unqualified messages in WAIT_INIT are ignored.
        restart("ooo restart");
        req("end in wait_init", 4'b0101, 3'b000);
        cycle("valid low init", 1'b1, 1'b0, 4'b0001, 3'b000, 1'b0, 1'b0);
        req("init after ooo", 4'b0001, 3'b000);

        // Sideband arbitration: initiator still sending keeps our valid pending.
        cycle("busy with tx", 1'b1, 1'b0, 4'h0, 3'b000, 1'b1, 1'b1);
        chk("valid held", 16'(o_valid_rx), 16'h0001);
        cycle("busy clear 2", 1'b1, 1'b0, 4'h0, 3'b000, 1'b1, 1'b0);
        req("repeat init", 4'b0001, 3'b000);
        chk("no resend", 16'(o_valid_rx), 16'h0000);
        cycle("busy+apply", 1'b1, 1'b1, 4'b0111, 3'b001, 1'b1, 1'b0);
        chk("set wins", 16'(o_valid_rx), 16'h0001);

        // Drop i_en in WAIT_APPLY: outputs clear, mask retained, flow restarts.
        restart("en drop restart");
        req("en drop init", 4'b0001, 3'b000);
        cycle("en drop", 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0);
        chk("mask retained", o_lane_mask, 16'h00FF);
        idle("re-enable");
        req("apply ignored", 4'b0111, 3'b011);
        req("re init", 4'b0001, 3'b000);
        req("re apply", 4'b0111, 3'b010);

        // Asynchronous reset mid-handshake clears everything, mask included.
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("post rst enable");
        req("post rst init", 4'b0001, 3'b000);

`ifdef REPAIR_RX_TIMEOUT_EN
        restart("tmo restart");
        for (int i = 0; i < int'(TB_TIMEOUT); i++) idle("tmo wait");
        chk("timeout set", 16'(o_timeout), 16'h0001);
        req("tmo blocked", 4'b0001, 3'b000);
        idle("tmo hold");
        cycle("tmo clear", 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 1'b0);
        chk("timeout cleared", 16'(o_timeout), 16'h0000);
        idle("tmo reenable");
        req("tmo init", 4'b0001, 3'b000);
`endif

        // Randomized traffic biased toward legal requests.
        for (int i = 0; i < 400; i++) begin
            int          r;
            logic [3:0]  msg;
            r   = int'($urandom_range(0, 3));
            msg = (r < 3) ? REQ[r] : 4'($urandom);
            cycle("random", ($urandom_range(0, 15) != 0), 1'($urandom), msg,
                  3'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
